gray_counter: RTL and testbench
===============================

Name: gray_counter

Overview:
- Parametrised N-bit Gray-code counter: keeps a registered count, presents it in Gray and binary form every cycle.
- Supports up/down counting, synchronous load (binary or Gray encoded), and wrap or saturate mode.
- Provides a terminal-count flag.
- Used as the pointer/sequence source for clock-domain-crossing FIFOs and as a glitch-safe position counter; the Gray output changes in at most one bit per cycle.

Parameters:
- N, 8: counter width in bits; legal range 1..32.
- SATURATE, 0: 0 = wrap at the limits; 1 = hold at the limits.
- RESET_VALUE, 0: binary count loaded on reset; must be < 2^N.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- en_i  input  1  count enable; one step per cycle while high.
- up_i  input  1  direction: 1 = increment, 0 = decrement; sampled only when en_i=1.
- load_i  input  1  synchronous load strobe.
- load_gray_i  input  1  1 = load_value_i is Gray encoded; 0 = binary; sampled only when load_i=1.
- load_value_i  input  N  value to load.
- gray_o  output  N  registered count, Gray encoded.
- bin_o  output  N  registered count, binary.
- tc_o  output  1  terminal-count flag, registered, one cycle per event.

Behaviour:
- Reset (rst_i=1 at an edge):
  - bin_o = RESET_VALUE.
  - gray_o = RESET_VALUE ^ (RESET_VALUE >> 1).
  - tc_o = 0.
  - Reset overrides load_i and en_i. Reset asserted mid-count takes effect at the next edge with no partial update.
- Invariant: gray_o == bin_o ^ (bin_o >> 1) in every cycle. Both are driven from flops; no combinational path from any input to any output.
- Priority at each edge: rst_i > load_i > en_i > hold.
- Load:
  - load_gray_i=0: bin_o <= load_value_i.
  - load_gray_i=1: bin_o <= Gray-to-binary of load_value_i, where bit i = XOR of load_value_i[N-1:i].
  - gray_o is updated consistently. tc_o <= 0. en_i is ignored that cycle.
  - Latency: the loaded value is visible on the cycle after the load edge.
- Count (en_i=1, load_i=0):
  - Up: bin+1 mod 2^N. Down: bin-1 mod 2^N. Latency is 1 cycle.
  - Each non-saturated step changes exactly one bit of gray_o.
- Terminal events:
  - Up step from 2^N-1, or down step from 0.
  - SATURATE=0: the count wraps (to 0, or to 2^N-1). tc_o=1 for the cycle showing the wrapped value.
  - SATURATE=1: the count holds at the limit and gray_o is unchanged. tc_o=1 for each cycle following an enabled step attempted at the limit.
  - A step away from a limit never raises tc_o.
- tc_o is 0 in every cycle not following a terminal event, including cycles after load, hold, or reset.
- Direction may change on any cycle; no pipeline state is carried, so a reversal takes effect immediately on the next step.
- N=1: gray_o == bin_o. The count toggles 0/1 with wrap, and every up step from 1 or down step from 0 is a terminal event.
- Arithmetic is unsigned, N bits. Internal increment/decrement is computed at N bits with explicit limit compare; no carry-out is used.

Test Plan:
- Reset/RESET_VALUE: N=4, RESET_VALUE=5, pulse rst_i -> bin_o=0101, gray_o=0111, tc_o=0; rst_i together with load_i=1 and load_value_i=9 -> outputs still 5/0111.
- Full up sweep with wrap: N=4, SATURATE=0, en_i=1, up_i=1 from 0 for 17 cycles -> bin_o 0..15 then 0. Every step differs in one gray_o bit. tc_o=1 only on the cycle bin_o returns to 0.
- Down wrap and direction reversal: N=3, start 1, down 2 steps -> 0 then 7 with tc_o=1 on 7. Then up_i=1 one step -> 0 with tc_o=1. Then up once more -> 1 with tc_o=0.
- Saturation: N=4, SATURATE=1, load 14, en up 3 cycles -> bin_o 15, 15, 15, gray_o stays 1000, tc_o 0, 1, 1. Then down one step -> 14, tc_o=0.
- Gray load: N=8, load_gray_i=1, load_value_i=8'b1100_0110 -> bin_o=8'b1000_0100 (132), gray_o=1100_0110 next cycle. Same cycle en_i=1 is ignored. load_gray_i=0 with value 132 gives identical outputs.
- Random soak: 10k cycles of random en/up/load/rst -> invariant gray_o==bin_o^(bin_o>>1) holds every cycle. Scoreboard model matches bin_o and tc_o exactly. Single-bit Gray change holds on every non-load, non-reset step.

Source files
------------

// File: rtl/gray_counter.sv
// N-bit up/down counter presenting its registered count in binary and Gray form.
// Supports binary or Gray synchronous load, wrap/saturate limits and a terminal-count flag.
module gray_counter #(
    parameter int unsigned N           = 8,
    parameter int unsigned SATURATE    = 0,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         up_i,
    input  logic         load_i,
    input  logic         load_gray_i,
    input  logic [N-1:0] load_value_i,
    output logic [N-1:0] gray_o,
    output logic [N-1:0] bin_o,
    output logic         tc_o
);

    localparam logic [N-1:0] RST_BIN  = RESET_VALUE[N-1:0];
    localparam logic [N-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
    localparam logic [N-1:0] ONE      = N'(1);
    localparam logic [N-1:0] MAX      = '1;
    localparam logic [N-1:0] MIN      = '0;
    localparam bit           SAT      = (SATURATE != 0);

    logic [N-1:0] bin_q, bin_d;
    logic [N-1:0] gray_q, gray_d;
    logic         tc_q, tc_d;

    logic [N-1:0] load_bin;
    logic [N-1:0] step_val;
    logic         at_limit;

    // Gray-to-binary: bit i is the XOR of all Gray bits at or above i.
    always_comb begin
        load_bin = '0;
        for (int k = 0; k < N; k++) begin
            load_bin = load_bin ^ (load_value_i >> k);
        end
    end

    always_comb begin
        at_limit = up_i ? (bin_q == MAX) : (bin_q == MIN);
        step_val = up_i ? (bin_q + ONE) : (bin_q - ONE);
    end

    always_comb begin
        bin_d = bin_q;
        tc_d  = 1'b0;
        if (load_i) begin
            bin_d = load_gray_i ? load_bin : load_value_i;
        end else if (en_i) begin
            if (at_limit) begin
                tc_d  = 1'b1;
                bin_d = SAT ? bin_q : step_val;
            end else begin
                bin_d = step_val;
            end
        end
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bin_q  <= RST_BIN;
            gray_q <= RST_GRAY;
            tc_q   <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            tc_q   <= tc_d;
        end
    end

    assign bin_o  = bin_q;
    assign gray_o = gray_q;
    assign tc_o   = tc_q;

endmodule

// File: tb/tb_gray_counter.sv
// Directed and soak bench for gray_counter across several widths/modes.
// All instances share one set of control inputs; each test loads its own start value.
module tb_gray_counter;

    logic        clk = 1'b0;
    logic        rst, en, up, ld, lg;
    logic [31:0] lv;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    // d4: N=4 wrap RV=5 | d3: N=3 wrap | ds: N=4 saturate | d8: N=8 wrap | d1: N=1
    logic [3:0] b4, g4;  logic t4;
    logic [2:0] b3, g3;  logic t3;
    logic [3:0] bs, gs;  logic ts;
    logic [7:0] b8, g8;  logic t8;
    logic [0:0] b1, g1;  logic t1;

    gray_counter #(.N(4), .SATURATE(0), .RESET_VALUE(5)) u4 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .load_i(ld),
        .load_gray_i(lg), .load_value_i(lv[3:0]),
        .gray_o(g4), .bin_o(b4), .tc_o(t4));
    gray_counter #(.N(3), .SATURATE(0), .RESET_VALUE(0)) u3 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .load_i(ld),
        .load_gray_i(lg), .load_value_i(lv[2:0]),
        .gray_o(g3), .bin_o(b3), .tc_o(t3));
    gray_counter #(.N(4), .SATURATE(1), .RESET_VALUE(0)) us (
        .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .load_i(ld),
        .load_gray_i(lg), .load_value_i(lv[3:0]),
        .gray_o(gs), .bin_o(bs), .tc_o(ts));
    gray_counter #(.N(8), .SATURATE(0), .RESET_VALUE(0)) u8 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .load_i(ld),
        .load_gray_i(lg), .load_value_i(lv[7:0]),
        .gray_o(g8), .bin_o(b8), .tc_o(t8));
    gray_counter #(.N(1), .SATURATE(0), .RESET_VALUE(0)) u1 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .load_i(ld),
        .load_gray_i(lg), .load_value_i(lv[0:0]),
        .gray_o(g1), .bin_o(b1), .tc_o(t1));

    logic [31:0] a_bin[5];
    logic [31:0] a_gray[5];
    logic        a_tc[5];
    assign a_bin[0] = 32'(b4);  assign a_gray[0] = 32'(g4);  assign a_tc[0] = t4;
    assign a_bin[1] = 32'(b3);  assign a_gray[1] = 32'(g3);  assign a_tc[1] = t3;
    assign a_bin[2] = 32'(bs);  assign a_gray[2] = 32'(gs);  assign a_tc[2] = ts;
    assign a_bin[3] = 32'(b8);  assign a_gray[3] = 32'(g8);  assign a_tc[3] = t8;
    assign a_bin[4] = 32'(b1);  assign a_gray[4] = 32'(g1);  assign a_tc[4] = t1;

    int          m_n[5]   = '{4, 3, 4, 8, 1};
    bit          m_sat[5] = '{0, 0, 1, 0, 0};
    logic [31:0] m_rv[5]  = '{5, 0, 0, 0, 0};

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        rst = 0; en = 0; up = 0; ld = 0; lg = 0; lv = '0;
    endtask

    task automatic load_bin(input logic [31:0] v);
        idle();
        ld = 1; lv = v;
        cyc();
        ld = 0;
    endtask

    task automatic test_reset;
        idle();
        rst = 1;
        cyc();
        vecs++;
        if (b4 !== 4'd5) begin
            errs++; $display("FAIL reset_bin: got %0d want 5", b4);
        end
        vecs++;
        if (g4 !== 4'b0111) begin
            errs++; $display("FAIL reset_gray: got %b want 0111", g4);
        end
        vecs++;
        if (t4 !== 1'b0) begin
            errs++; $display("FAIL reset_tc: got %b want 0", t4);
        end
        vecs++;
        if (g8 !== 8'h00 || b8 !== 8'h00) begin
            errs++; $display("FAIL reset_n8: got %h/%h want 00/00", b8, g8);
        end
        ld = 1; lv = 9; en = 1; up = 1;
        cyc();
        vecs++;
        if (b4 !== 4'd5 || g4 !== 4'b0111) begin
            errs++; $display("FAIL reset_over_load: got %0d/%b want 5/0111", b4, g4);
        end
        vecs++;
        if (t4 !== 1'b0) begin
            errs++; $display("FAIL reset_over_load_tc: got %b want 0", t4);
        end
        idle();
    endtask

    task automatic test_up_sweep;
        logic [3:0] prev, eb;
        load_bin(0);
        vecs++;
        if (b4 !== 4'd0 || t4 !== 1'b0) begin
            errs++; $display("FAIL sweep_start: got %0d tc %b want 0 tc 0", b4, t4);
        end
        prev = g4;
        en = 1; up = 1;
        for (int i = 1; i <= 16; i++) begin
            cyc();
            eb = 4'(i);
            vecs++;
            if (b4 !== eb || g4 !== (eb ^ (eb >> 1))) begin
                errs++;
                $display("FAIL sweep_val[%0d]: got %0d/%b want %0d/%b", i, b4, g4, eb, eb ^ (eb >> 1));
            end
            vecs++;
            if (t4 !== (i == 16)) begin
                errs++; $display("FAIL sweep_tc[%0d]: got %b want %b", i, t4, i == 16);
            end
            vecs++;
            if ($countones(g4 ^ prev) != 1) begin
                errs++; $display("FAIL sweep_onebit[%0d]: got %b->%b want one bit", i, prev, g4);
            end
            prev = g4;
        end
        idle();
    endtask

    task automatic test_down_reverse;
        logic [2:0] eb[4]  = '{3'd0, 3'd7, 3'd0, 3'd1};
        logic       et[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic       dir[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        load_bin(1);
        en = 1;
        for (int i = 0; i < 4; i++) begin
            up = dir[i];
            cyc();
            vecs++;
            if (b3 !== eb[i] || t3 !== et[i] || g3 !== (eb[i] ^ (eb[i] >> 1))) begin
                errs++;
                $display("FAIL down_rev[%0d]: got %0d/%b tc %b want %0d tc %b", i, b3, g3, t3, eb[i], et[i]);
            end
        end
        idle();
    endtask

    task automatic test_saturate;
        logic t_exp[3] = '{1'b0, 1'b1, 1'b1};
        load_bin(14);
        en = 1; up = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            vecs++;
            if (bs !== 4'd15 || gs !== 4'b1000 || ts !== t_exp[i]) begin
                errs++;
                $display("FAIL sat_hi[%0d]: got %0d/%b tc %b want 15/1000 tc %b", i, bs, gs, ts, t_exp[i]);
            end
        end
        up = 0;
        cyc();
        vecs++;
        if (bs !== 4'd14 || ts !== 1'b0) begin
            errs++; $display("FAIL sat_away: got %0d tc %b want 14 tc 0", bs, ts);
        end
        load_bin(0);
        en = 1; up = 0;
        cyc();
        vecs++;
        if (bs !== 4'd0 || gs !== 4'd0 || ts !== 1'b1) begin
            errs++; $display("FAIL sat_lo: got %0d/%b tc %b want 0/0000 tc 1", bs, gs, ts);
        end
        idle();
    endtask

    task automatic test_hold;
        load_bin(15);
        en = 1; up = 1;
        cyc();
        en = 0;
        cyc();
        vecs++;
        if (b4 !== 4'd0 || t4 !== 1'b0) begin
            errs++; $display("FAIL hold_after_tc: got %0d tc %b want 0 tc 0", b4, t4);
        end
        vecs++;
        if (bs !== 4'd15 || ts !== 1'b0) begin
            errs++; $display("FAIL hold_sat: got %0d tc %b want 15 tc 0", bs, ts);
        end
        idle();
    endtask

    task automatic test_gray_load;
        idle();
        ld = 1; lg = 1; lv = 32'hC6; en = 1; up = 1;
        cyc();
        vecs++;
        if (b8 !== 8'h84 || g8 !== 8'hC6 || t8 !== 1'b0) begin
            errs++; $display("FAIL gray_load: got %h/%h tc %b want 84/c6 tc 0", b8, g8, t8);
        end
        lg = 0; lv = 132;
        cyc();
        vecs++;
        if (b8 !== 8'h84 || g8 !== 8'hC6 || t8 !== 1'b0) begin
            errs++; $display("FAIL bin_load: got %h/%h tc %b want 84/c6 tc 0", b8, g8, t8);
        end
        ld = 0; en = 1; up = 1;
        load_bin(255);
        en = 1; up = 1;
        cyc();
        ld = 1; lg = 1; lv = 32'h80;
        cyc();
        vecs++;
        if (b8 !== 8'hFF || g8 !== 8'h80 || t8 !== 1'b0) begin
            errs++; $display("FAIL load_clears_tc: got %h/%h tc %b want ff/80 tc 0", b8, g8, t8);
        end
        idle();
    endtask

    task automatic test_n1;
        logic eb[3]  = '{1'b1, 1'b0, 1'b1};
        logic et[3]  = '{1'b0, 1'b1, 1'b1};
        logic dir[3] = '{1'b1, 1'b1, 1'b0};
        load_bin(0);
        en = 1;
        for (int i = 0; i < 3; i++) begin
            up = dir[i];
            cyc();
            vecs++;
            if (b1 !== eb[i] || g1 !== eb[i] || t1 !== et[i]) begin
                errs++;
                $display("FAIL n1[%0d]: got %b/%b tc %b want %b tc %b", i, b1, g1, t1, eb[i], et[i]);
            end
        end
        idle();
    endtask

    task automatic test_soak;
        logic [31:0] mb[5];
        logic [31:0] pg[5];
        logic [31:0] mask, v, r, old;
        bit          mt[5];
        bit          quiet;
        idle();
        rst = 1;
        cyc();
        for (int d = 0; d < 5; d++) begin
            mb[d] = m_rv[d];
            mt[d] = 0;
            pg[d] = a_gray[d];
        end
        for (int c = 0; c < 10000; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            ld  = ($urandom_range(0, 9) == 0);
            lg  = $urandom_range(0, 1);
            en  = ($urandom_range(0, 3) != 0);
            up  = $urandom_range(0, 1);
            lv  = $urandom;
            cyc();
            quiet = !rst && !ld;
            for (int d = 0; d < 5; d++) begin
                mask = (32'd1 << m_n[d]) - 1;
                old  = mb[d];
                mt[d] = 0;
                if (rst) begin
                    mb[d] = m_rv[d];
                end else if (ld) begin
                    v = lv & mask;
                    r = 0;
                    for (int k = 0; k < m_n[d]; k++) r = r ^ (v >> k);
                    mb[d] = lg ? (r & mask) : v;
                end else if (en && up) begin
                    if (mb[d] == mask) begin
                        mt[d] = 1;
                        mb[d] = m_sat[d] ? mask : 0;
                    end else begin
                        mb[d] = mb[d] + 1;
                    end
                end else if (en) begin
                    if (mb[d] == 0) begin
                        mt[d] = 1;
                        mb[d] = m_sat[d] ? 0 : mask;
                    end else begin
                        mb[d] = mb[d] - 1;
                    end
                end
                vecs++;
                if (a_bin[d] !== mb[d] || a_tc[d] !== mt[d]) begin
                    errs++;
                    $display("FAIL soak_model[%0d] c%0d: got %h tc %b want %h tc %b", d, c, a_bin[d], a_tc[d], mb[d], mt[d]);
                end
                vecs++;
                if (a_gray[d] !== (a_bin[d] ^ (a_bin[d] >> 1))) begin
                    errs++;
                    $display("FAIL soak_inv[%0d] c%0d: got gray %h want %h", d, c, a_gray[d], a_bin[d] ^ (a_bin[d] >> 1));
                end
                if (quiet) begin
                    vecs++;
                    if ($countones(a_gray[d] ^ pg[d]) != ((mb[d] != old) ? 1 : 0)) begin
                        errs++;
                        $display("FAIL soak_onebit[%0d] c%0d: got %h->%h", d, c, pg[d], a_gray[d]);
                    end
                end
                pg[d] = a_gray[d];
            end
        end
        idle();
    endtask

    initial begin
        idle();
        rst = 1;
        test_reset();
        test_up_sweep();
        test_down_reverse();
        test_saturate();
        test_hold();
        test_gray_load();
        test_n1();
        test_soak();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
